// File: rtl/pad_poller.sv
// Polls NUM_PADS NES/SNES controllers in parallel over a shared latch/clock pair.
// Define PAD_PRESENCE_DETECT_EN to shift one extra probe bit for controller detection.
module pad_poller #(
    parameter int unsigned NUM_PADS     = 2,
    parameter int unsigned NUM_BITS     = 16,
    parameter int unsigned LATCH_CYCLES = 768,
    parameter int unsigned HALF_CYCLES  = 384,
    parameter int unsigned GAP_CYCLES   = 64000
) (
    input  logic                         system_clk_64MHz,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS-1:0]          present,
    output logic                         frame_valid,
    output logic                         busy
);

`ifdef PAD_PRESENCE_DETECT_EN
    localparam int unsigned TOTAL = NUM_BITS + 1;
`else
    localparam int unsigned TOTAL = NUM_BITS;
`endif
    localparam int unsigned MAX_LH  = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_LH > GAP_CYCLES) ? MAX_LH : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned IDX_W   = $clog2(TOTAL);

    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TOTAL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StLow,
        StHigh,
        StGap
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_PADS-1:0]          sync1_q, sync2_q;
    logic [NUM_PADS*TOTAL-1:0]    shadow_q, shadow_d;
    logic [NUM_PADS*NUM_BITS-1:0] buttons_q, buttons_d;
    logic [NUM_PADS-1:0]          present_q, present_d;
    logic                         pad_latch_q, pad_clk_q, frame_valid_q;
    logic                         sample, frame_done;

    // Pads idle high, so the synchroniser resets to "unpressed".
    always_ff @(posedge system_clk_64MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= pad_data;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sample     = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StLatch;
                    cnt_d   = '0;
                end
            end
            StLatch: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLow: begin
                if (cnt_q == HALF_LAST) begin
                    sample = 1'b1;
                    cnt_d  = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d    = StGap;
                        frame_done = 1'b1;
                    end else begin
                        state_d = StHigh;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = enable ? StLatch : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        if (sample) begin
            for (int unsigned p = 0; p < NUM_PADS; p++) begin
                for (int unsigned k = 0; k < TOTAL; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        shadow_d[p*TOTAL+k] = ~sync2_q[p];
                    end
                end
            end
        end
    end

    // Built from shadow_d so the final bit sampled on the GAP transition is included.
    always_comb begin
        buttons_d = '0;
        present_d = '1;
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
`ifdef PAD_PRESENCE_DETECT_EN
            present_d[p] = shadow_d[p*TOTAL+NUM_BITS];
`endif
            for (int unsigned k = 0; k < NUM_BITS; k++) begin
                buttons_d[p*NUM_BITS+k] = shadow_d[p*TOTAL+k] & present_d[p];
            end
        end
    end

    always_ff @(posedge system_clk_64MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            pad_latch_q   <= 1'b0;
            pad_clk_q     <= 1'b0;
            buttons_q     <= '0;
            present_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            pad_latch_q   <= (state_d == StLatch);
            pad_clk_q     <= (state_d == StHigh);
            frame_valid_q <= frame_done;
            if (frame_done) begin
                buttons_q <= buttons_d;
                present_q <= present_d;
            end
        end
    end

    assign pad_latch   = pad_latch_q;
    assign pad_clk     = pad_clk_q;
    assign buttons     = buttons_q;
    assign present     = present_q;
    assign frame_valid = frame_valid_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_pad_poller.sv
// Scoreboard bench for pad_poller: pad models, frame checks, timing and enable/reset scenarios.
module tb_pad_poller;

    localparam int unsigned N_PADS = 2;
    localparam int unsigned N_BITS = 16;
    localparam int unsigned LATCH  = 8;
    localparam int unsigned HALF   = 4;
    localparam int unsigned GAP    = 30;
`ifdef PAD_PRESENCE_DETECT_EN
    localparam int unsigned TOTAL = N_BITS + 1;
`else
    localparam int unsigned TOTAL = N_BITS;
`endif

    logic                       clk;
    logic                       rst_n;
    logic                       enable;
    logic [N_PADS-1:0]          pad_data;
    logic                       pad_latch;
    logic                       pad_clk;
    logic [N_PADS*N_BITS-1:0]   buttons;
    logic [N_PADS-1:0]          present;
    logic                       frame_valid;
    logic                       busy;

    logic       en8;
    logic [0:0] pad8;
    logic       latch8, clk8, fv8, busy8;
    logic [7:0] buttons8;
    logic [0:0] present8;

    logic [15:0] pat0, pat1;
    logic        plug1;
    logic [16:0] sh0, sh1;
    logic        pclk_d;
    logic [8:0]  sh8;
    logic        pclk8_d;

    logic [33:0] sb[$];
    logic [33:0] sb_exp;
    int          n_cmp, n_bad, fv_cnt, got8;
    logic        mon_on, prev_fv, prev_clk;
    int          latch_run, hi_run, pulses, gap_run;
    logic        in_gap;

    pad_poller #(
        .NUM_PADS    (N_PADS),
        .NUM_BITS    (N_BITS),
        .LATCH_CYCLES(LATCH),
        .HALF_CYCLES (HALF),
        .GAP_CYCLES  (GAP)
    ) dut (
        .system_clk_64MHz(clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .pad_data        (pad_data),
        .pad_latch       (pad_latch),
        .pad_clk         (pad_clk),
        .buttons         (buttons),
        .present         (present),
        .frame_valid     (frame_valid),
        .busy            (busy)
    );

    pad_poller #(
        .NUM_PADS    (1),
        .NUM_BITS    (8),
        .LATCH_CYCLES(LATCH),
        .HALF_CYCLES (HALF),
        .GAP_CYCLES  (GAP)
    ) dut8 (
        .system_clk_64MHz(clk),
        .rst_n           (rst_n),
        .enable          (en8),
        .pad_data        (pad8),
        .pad_latch       (latch8),
        .pad_clk         (clk8),
        .buttons         (buttons8),
        .present         (present8),
        .frame_valid     (fv8),
        .busy            (busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller models: load on latch, shift one bit per pad_clk rise, trailing zero probe.
    always @(posedge clk) begin
        if (pad_latch) begin
            sh0 <= {1'b0, pat0};
            sh1 <= {1'b0, pat1};
        end else if (pad_clk && !pclk_d) begin
            sh0 <= sh0 >> 1;
            sh1 <= sh1 >> 1;
        end
        pclk_d <= pad_clk;
        if (latch8) sh8 <= {1'b0, 8'b0101_0101};
        else if (clk8 && !pclk8_d) sh8 <= sh8 >> 1;
        pclk8_d <= clk8;
    end

    assign pad_data = {(plug1 ? sh1[0] : 1'b1), sh0[0]};
    assign pad8     = sh8[0];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [33:0] exp_of(input logic [15:0] p0, input logic [15:0] p1,
                                           input logic plug);
        logic [1:0] pr;
`ifdef PAD_PRESENCE_DETECT_EN
        pr = {plug, 1'b1};
`else
        pr = 2'b11;
`endif
        return {pr, (plug ? ~p1 : 16'h0000), ~p0};
    endfunction

    task automatic queue_frame(input logic [15:0] p0, input logic [15:0] p1, input logic plug);
        pat0  = p0;
        pat1  = p1;
        plug1 = plug;
        sb.push_back(exp_of(p0, p1, plug));
    endtask

    task automatic wait_fv();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_valid) return;
        end
        check_val("fv_timeout", 64'(frame_valid), 64'(1));
    endtask

    task automatic wait_rises(input int n);
        int   cnt;
        logic prev;
        cnt  = 0;
        prev = pad_clk;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pad_clk && !prev) cnt++;
            prev = pad_clk;
            if (cnt == n) return;
        end
        check_val("clk_rise_timeout", 64'(cnt), 64'(n));
    endtask

    // Scoreboard pop plus timing monitor, both sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_fv) check_val("fv_one_cycle", 64'(frame_valid), 64'(0));
            prev_fv = frame_valid;
            if (frame_valid) begin
                fv_cnt++;
                if (sb.size() == 0) begin
                    check_val("fv_unexpected", 64'(frame_valid), 64'(0));
                end else begin
                    sb_exp = sb.pop_front();
                    check_val("frame", 64'({present, buttons}), 64'(sb_exp));
                end
            end
            if (!rst_n || !mon_on) begin
                latch_run = 0;
                hi_run    = 0;
                pulses    = 0;
                gap_run   = 0;
                in_gap    = 1'b0;
                prev_clk  = 1'b0;
            end else begin
                if (pad_latch) begin
                    latch_run++;
                end else if (latch_run != 0) begin
                    check_val("latch_width", 64'(latch_run), 64'(LATCH));
                    latch_run = 0;
                    pulses    = 0;
                end
                if (pad_clk) begin
                    if (!prev_clk) pulses++;
                    hi_run++;
                end else if (hi_run != 0) begin
                    check_val("clk_high_width", 64'(hi_run), 64'(HALF));
                    hi_run = 0;
                end
                if (frame_valid) begin
                    check_val("clk_pulses", 64'(pulses), 64'(TOTAL - 1));
                    in_gap  = 1'b1;
                    gap_run = 1;
                end else if (in_gap) begin
                    if (pad_latch) begin
                        check_val("gap_width", 64'(gap_run), 64'(GAP));
                        in_gap = 1'b0;
                    end else if (!busy) begin
                        in_gap = 1'b0;
                    end else begin
                        gap_run++;
                    end
                end
                prev_clk = pad_clk;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fv8) begin
                check_val("nes_buttons", 64'(buttons8), 64'(8'hAA));
                check_val("nes_present", 64'(present8), 64'(1));
                got8++;
            end
        end
    end

    initial begin
        int n_fv0;
        n_cmp   = 0;
        n_bad   = 0;
        fv_cnt  = 0;
        got8    = 0;
        prev_fv = 1'b0;
        mon_on  = 1'b1;
        rst_n   = 1'b0;
        enable  = 1'b0;
        en8     = 1'b0;
        plug1   = 1'b1;
        pat0    = 16'hFFFF;
        pat1    = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_latch", 64'(pad_latch), 64'(0));
        check_val("rst_clk", 64'(pad_clk), 64'(0));
        check_val("rst_buttons", 64'(buttons), 64'(0));
        check_val("rst_present", 64'(present), 64'(0));
        check_val("rst_fv", 64'(frame_valid), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        en8   = 1'b1;

        // A pressed on pad 0
        queue_frame(16'hFFFE, 16'h5A5A, 1'b1);
        enable = 1'b1;
        wait_fv();
        check_val("a_pressed", 64'(buttons[15:0]), 64'(16'h0001));

        @(negedge clk);
        queue_frame(16'h0000, 16'hFFFF, 1'b1);
        wait_fv();

        // pad 1 unplugged (data pulled high)
        @(negedge clk);
        queue_frame(16'($urandom), 16'h1234, 1'b0);
        wait_fv();
        check_val("absent_hi", 64'(buttons[31:16]), 64'(0));

        // enable dropped in the middle of bit 5
        @(negedge clk);
        queue_frame(16'hA5C3, 16'h0F0F, 1'b1);
        n_fv0 = fv_cnt;
        wait_rises(6);
        enable = 1'b0;
        wait_fv();
        repeat (GAP + 5) @(negedge clk);
        check_val("idle_busy", 64'(busy), 64'(0));
        check_val("idle_latch", 64'(pad_latch), 64'(0));
        check_val("one_fv", 64'(fv_cnt), 64'(n_fv0 + 1));
        repeat (40) @(negedge clk);
        check_val("stay_idle", 64'(busy), 64'(0));

        // reset during HIGH of bit 3
        mon_on = 1'b0;
        pat0   = 16'h1111;
        pat1   = 16'h2222;
        enable = 1'b1;
        wait_rises(4);
        @(posedge clk);
        #1;
        check_val("in_high", 64'(pad_clk), 64'(1));
        rst_n = 1'b0;
        #1;
        check_val("arst_clk", 64'(pad_clk), 64'(0));
        check_val("arst_buttons", 64'(buttons), 64'(0));
        check_val("arst_present", 64'(present), 64'(0));
        check_val("arst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        queue_frame(16'h3C3C, 16'hC3C3, 1'b1);
        mon_on = 1'b1;
        rst_n  = 1'b1;
        wait_fv();

        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < GAP + 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_val("final_idle", 64'(busy), 64'(0));
        check_val("sb_drained", 64'(sb.size()), 64'(0));
        check_val("nes_seen", 64'(got8 > 0), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pad_poller.md
PAD_POLLER -- requirements
Module: pad_poller

Interface
REQ-001 The parameter NUM_PADS SHALL default to 2 and set the number of controllers polled in parallel (1..4).
REQ-002 The parameter NUM_BITS SHALL default to 16 and set the button bits per frame (8 = NES, 16 = SNES).
REQ-003 The parameter LATCH_CYCLES SHALL default to 768 and set the latch-high width in clocks (12 us at 64 MHz).
REQ-004 The parameter HALF_CYCLES SHALL default to 384 and set each pad_clk half-period in clocks (6 us at 64 MHz).
REQ-005 The parameter GAP_CYCLES SHALL default to 64000 and set the idle clocks between frames (1 ms at 64 MHz).
REQ-006 system_clk_64MHz  in  1  sole clock; all flops on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 enable  in  1  high = free-running polling; low = stop after the current frame.
REQ-009 pad_data  in  NUM_PADS  serial data from each controller; active-low, pulled up when unplugged.
REQ-010 pad_latch  out  1  latch strobe shared by all pads.
REQ-011 pad_clk  out  1  shift clock shared by all pads.
REQ-012 buttons  out  NUM_PADS*NUM_BITS  active-high button states; pad p bit k is at index p*NUM_BITS+k, bit 0 = first bit shifted.
REQ-013 present  out  NUM_PADS  one bit per pad, 1 = controller detected.
REQ-014 frame_valid  out  1  one-cycle pulse when buttons and present update.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 Each pad_data bit SHALL pass through a 2-flop synchroniser; every "sample" below uses the synchronised value.
REQ-017 The FSM SHALL have five states: IDLE, LATCH, LOW, HIGH, GAP.
REQ-018 IDLE: pad_latch=0, pad_clk=0; when enable=1, the FSM SHALL go to LATCH with the counter cleared.
REQ-019 LATCH: pad_latch=1 for exactly LATCH_CYCLES clocks, then the FSM SHALL go to LOW with the bit index at 0.
REQ-020 LOW: pad_clk=0 for HALF_CYCLES clocks; the inverted data of every pad SHALL be sampled into a shadow register on the last LOW clock.
REQ-021 After LOW, if the bit index is below TOTAL-1, the FSM SHALL go to HIGH; otherwise it SHALL go to GAP. TOTAL = NUM_BITS, or NUM_BITS+1 with presence detection.
REQ-022 HIGH: pad_clk=1 for HALF_CYCLES clocks, then the bit index SHALL increment and the FSM SHALL return to LOW.
REQ-023 On entry to GAP, the shadow register SHALL be copied to buttons in one cycle, together with a single frame_valid pulse; partial frames SHALL never be visible on buttons.
REQ-024 GAP: pad_latch=0, pad_clk=0 for GAP_CYCLES clocks; the FSM SHALL then go to LATCH if enable=1, else to IDLE.
REQ-025 A fall of enable mid-frame SHALL NOT abort the frame; the frame SHALL complete through GAP.
REQ-026 The counter width SHALL be $clog2 of the largest of LATCH_CYCLES, HALF_CYCLES and GAP_CYCLES, plus 1; the counter SHALL never wrap.
REQ-027 pad_latch and pad_clk SHALL be driven directly from flops (glitch-free).

Reset
REQ-028 While rst_n=0, all outputs and flops SHALL clear immediately (asynchronously): state=IDLE, pad_latch=0, pad_clk=0, buttons=0, present=0, frame_valid=0, busy=0, counter and bit index 0, synchroniser flops reset to 1 (unpressed).
REQ-029 Reset asserted mid-frame SHALL discard the shadow register; polling SHALL restart from IDLE on the first clock after rst_n rises.

Configuration
REQ-030 With PAD_PRESENCE_DETECT_EN defined, one extra probe bit (index NUM_BITS) SHALL be shifted; present[p]=1 when that raw sample is 0, and buttons for an absent pad SHALL be forced to 0.
REQ-031 Without PAD_PRESENCE_DETECT_EN, no probe bit SHALL be shifted (TOTAL=NUM_BITS), present SHALL be all ones after the first frame_valid, and buttons SHALL be unmasked.

Verification
REQ-032 Scenario: defaults, enable=1, pad0 model drives A pressed (raw bit0=0) -> after the first frame, buttons[0]=1, buttons[15:1]=0, frame_valid high for exactly one cycle.
REQ-033 Scenario: timing check -> pad_latch high for exactly 768 clocks, 15 pad_clk pulses of 384 clocks high each (16 with presence), 64000-clock gap between frames.
REQ-034 Scenario: PAD_PRESENCE_DETECT_EN defined, pad1 pad_data tied to 1 -> present=2'b01, buttons[31:16]=0.
REQ-035 Scenario: NUM_BITS=8, NUM_PADS=1, pattern 8'b0101_0101 raw -> buttons=8'hAA.
REQ-036 Scenario: enable dropped at the middle of bit 5 -> frame completes, one frame_valid, then IDLE with busy=0.
REQ-037 Scenario: rst_n pulsed low during HIGH of bit 3 -> pad_clk=0 and buttons=0 in the same cycle; the next frame_valid carries a fresh full frame.
